aes_core_arbiter: RTL
=====================

// Module: aes_core_arbiter
// PURPOSE
//  Shares one AES_128_bit encryption core between two requesters, each using a valid/ready interface.
//  Round-robin arbitration selects one requester. The block registers that requester's block and key.
//  It drives them onto the core inputs and holds them stable for CORE_LAT cycles.
//  It then captures the core output and returns it on the granting port's response channel.
//  It sits between the stream front-ends and the AES core, which has no handshake of its own.
// PARAMETERS
//  CORE_LAT  30  cycles from stable core inputs to valid aes_out_data (min 1)
//  LAT_W     5   wait-counter width; 2**LAT_W must be >= CORE_LAT
// PORTS
//  clk            in   1    rising-edge clock
//  rst_n          in   1    synchronous active-low reset
//  req0_valid     in   1    requester 0 has a block
//  req0_ready     out  1    requester 0 block accepted this cycle
//  req0_data      in   128  requester 0 plaintext
//  req0_key       in   128  requester 0 key
//  req1_valid/req1_ready/req1_data/req1_key  same as port 0, for requester 1
//  rsp0_valid     out  1    ciphertext available for requester 0
//  rsp0_ready     in   1    requester 0 consumes the response
//  rsp1_valid/rsp1_ready                     same as port 0, for requester 1
//  rsp_data       out  128  ciphertext; meaningful only while rsp0_valid or rsp1_valid is high
//  aes_inp_data   out  128  to core inp_data
//  aes_inp_key    out  128  to core inp_key
//  aes_out_data   in   128  from core out_data
//  busy           out  1    high in any state other than IDLE
//  blk_cnt0       out  32   completed responses to requester 0 (see CONFIGURATION)
//  blk_cnt1       out  32   completed responses to requester 1
// BEHAVIOUR
//  States:
//   - IDLE -> WAIT on an accept.
//   - WAIT -> RESP when cnt == CORE_LAT-1.
//   - RESP -> IDLE on the granted port's rsp_valid & rsp_ready.
//  Arbitration, in IDLE only:
//   - Only one port valid: that port is granted.
//   - Both ports valid: grant the port != last_grant.
//   - reqX_ready = (state==IDLE) & grantX. The ready signals are combinational and never both high.
//  Accept edge (reqX_valid & reqX_ready):
//   - aes_inp_data <= reqX_data; aes_inp_key <= reqX_key.
//   - owner <= X; last_grant <= X; cnt <= 0.
//  WAIT: cnt increments each cycle. aes_inp_* hold their values until the next accept, including after RESP.
//  Edge with cnt == CORE_LAT-1: rsp_data <= aes_out_data; state <= RESP.
//   - rsp<owner>_valid rises exactly CORE_LAT cycles after the accept edge.
//  RESP:
//   - rsp_data is stable and only rsp<owner>_valid is high.
//   - rspX_ready held low: stay in RESP indefinitely; no new request is accepted.
//  No overlap: the response handshake edge returns to IDLE; the next accept is earliest one cycle later.
//   - Best-case throughput is 1 block per CORE_LAT+2 cycles.
//  rspX_ready asserted while rspX_valid is low: ignored.
//  Request inputs are sampled only on the accept edge. Changes while not ready are ignored.
//  Reset (rst_n==0 at an edge):
//   - State IDLE; cnt=0; last_grant=1, so port 0 wins the first tie.
//   - aes_inp_data/aes_inp_key/rsp_data = 0; all ready/valid/busy = 0; blk_cnt* = 0.
//   - Reset mid-WAIT/RESP drops the in-flight block and produces no response.
// CONFIGURATION
//  AES_ARB_PERF_CNT_EN defined:
//   - blk_cntX increments on each rspX_valid & rspX_ready and wraps at 2**32-1 -> 0.
//  Not defined: blk_cnt0/blk_cnt1 are tied to 32'h0 and no counter registers exist.
// TESTING
//  Testbench instantiates AES_128_bit as the core; clk period 10 ns.
//  Reference: the same core driven directly with the same data/key.
//  1 Single block, port 0:
//    - Stimulus: data=128'h54494D47206E616C6F4E20726F6E6F43, key=128'h100F0E0D0C0B0A090807060504030201.
//    - Expect req0_ready in the same cycle.
//    - Expect rsp0_valid 30 cycles after the accept, with rsp_data == reference output.
//  2 Tie:
//    - Stimulus: req0/req1 valid together after reset.
//    - Expect port 0 served first, then port 1 served next.
//    - Expect each rsp_data to match its own data/key reference.
//  3 Fairness:
//    - Stimulus: both ports valid continuously for 6 blocks.
//    - Expect grants alternating 0,1,0,1,0,1 and never 2 consecutive to one port.
//  4 Backpressure:
//    - Stimulus: rsp1_ready held low for 50 cycles.
//    - Expect rsp1_valid and rsp_data stable, busy=1, req0_ready=0 throughout.
//    - Expect the IDLE state to return one cycle after ready goes high.
//  5 Reset mid-WAIT:
//    - Stimulus: assert rst_n=0 10 cycles after an accept.
//    - Expect all outputs 0 the next cycle and no rsp_valid afterwards.
//  6 Counters (AES_ARB_PERF_CNT_EN):
//    - Stimulus: 3 blocks on port 0 and 2 on port 1.
//    - Expect blk_cnt0=3, blk_cnt1=2.
//    - Without the macro, expect both counters 0.

Source files
------------

// File: rtl/aes_core_arbiter_if.sv
// Request/response handshake bundle between the two stream front-ends and the AES core arbiter.
// The master modport is the front-end side and the slave modport is the arbiter side.
interface aes_core_arbiter_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_data;
  logic [127:0] req0_key;
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_data;
  logic [127:0] req1_key;
  logic         rsp0_valid;
  logic         rsp0_ready;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [127:0] rsp_data;

  modport master (
    output req0_valid, req0_data, req0_key, rsp0_ready,
    output req1_valid, req1_data, req1_key, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );

  modport slave (
    input  req0_valid, req0_data, req0_key, rsp0_ready,
    input  req1_valid, req1_data, req1_key, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one handshake-less AES-128 core between two requesters.
// Define AES_ARB_PERF_CNT_EN to build the per-port completed-response counters.
module aes_core_arbiter #(
  parameter int CORE_LAT = 30,
  parameter int LAT_W    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  aes_core_arbiter_if.slave bus,
  output logic [127:0]  aes_inp_data,
  output logic [127:0]  aes_inp_key,
  input  logic [127:0]  aes_out_data,
  output logic          busy,
  output logic [31:0]   blk_cnt0,
  output logic [31:0]   blk_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic         last_grant_q, last_grant_d;
  logic         owner_q, owner_d;
  logic [127:0] inp_data_q, inp_data_d;
  logic [127:0] inp_key_q, inp_key_d;
  logic [127:0] rsp_data_q, rsp_data_d;

  logic grant0, grant1;
  logic accept0, accept1, accept;
  logic lat_done;
  logic rsp_hs0, rsp_hs1, rsp_hs;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant0   = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    grant1   = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    accept0  = bus.req0_valid & bus.req0_ready;
    accept1  = bus.req1_valid & bus.req1_ready;
    accept   = accept0 | accept1;
    lat_done = (cnt_q == LAT_W'(CORE_LAT - 1));
    rsp_hs0  = bus.rsp0_valid & bus.rsp0_ready;
    rsp_hs1  = bus.rsp1_valid & bus.rsp1_ready;
    rsp_hs   = rsp_hs0 | rsp_hs1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      inp_data_q   <= '0;
      inp_key_q    <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      inp_data_q   <= inp_data_d;
      inp_key_q    <= inp_key_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = WAIT;
      WAIT:    if (lat_done) state_d = RESP;
      RESP:    if (rsp_hs)   state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Core inputs stay frozen from one accept to the next, even across RESP and IDLE.
  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    inp_data_d   = inp_data_q;
    inp_key_d    = inp_key_q;
    rsp_data_d   = rsp_data_q;
    if (accept) begin
      inp_data_d   = accept1 ? bus.req1_data : bus.req0_data;
      inp_key_d    = accept1 ? bus.req1_key  : bus.req0_key;
      owner_d      = accept1;
      last_grant_d = accept1;
      cnt_d        = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + LAT_W'(1);
      if (lat_done) rsp_data_d = aes_out_data;
    end
  end

  always_comb begin
    bus.req0_ready = (state_q == IDLE) & grant0;
    bus.req1_ready = (state_q == IDLE) & grant1;
    bus.rsp0_valid = (state_q == RESP) & ~owner_q;
    bus.rsp1_valid = (state_q == RESP) & owner_q;
    busy           = (state_q != IDLE);
  end

  assign bus.rsp_data  = rsp_data_q;
  assign aes_inp_data  = inp_data_q;
  assign aes_inp_key   = inp_key_q;

`ifdef AES_ARB_PERF_CNT_EN
  logic [31:0] blk_cnt0_q, blk_cnt0_d;
  logic [31:0] blk_cnt1_q, blk_cnt1_d;

  always_comb begin
    blk_cnt0_d = blk_cnt0_q + {31'd0, rsp_hs0};
    blk_cnt1_d = blk_cnt1_q + {31'd0, rsp_hs1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_cnt0_q <= '0;
      blk_cnt1_q <= '0;
    end else begin
      blk_cnt0_q <= blk_cnt0_d;
      blk_cnt1_q <= blk_cnt1_d;
    end
  end

  assign blk_cnt0 = blk_cnt0_q;
  assign blk_cnt1 = blk_cnt1_q;
`else
  assign blk_cnt0 = 32'h0;
  assign blk_cnt1 = 32'h0;
`endif

endmodule
